// File: rtl/bsr_seq.sv
// bsr_seq: round-robin shared shift-right sequencer.
// Two requesters, 2-bit/1-bit steps per cycle, registered result.
module bsr_seq #(
    parameter int D_WIDTH = 32,
    parameter int SH_W    = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ0,
    input  logic               REQ1,
    input  logic [SH_W-1:0]    SHAMT0,
    input  logic [SH_W-1:0]    SHAMT1,
    input  logic               ARITH0,
    input  logic               ARITH1,
    input  logic [D_WIDTH-1:0] D_IN0,
    input  logic [D_WIDTH-1:0] D_IN1,
    output logic               GNT0,
    output logic               GNT1,
    output logic               BUSY,
    output logic               VALID,
    output logic               RID,
    output logic [D_WIDTH-1:0] D_OUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic [D_WIDTH-1:0] dout_q, dout_d;
    logic [SH_W-1:0]    rem_q, rem_d;
    logic               ar_q, ar_d;
    logic               last_q, last_d;
    logic               rid_q, rid_d;

    logic               gnt0, gnt1;
    logic [D_WIDTH-1:0] op_data;
    logic [SH_W-1:0]    op_shamt;
    logic               op_arith;
    logic               fill;

    // Round-robin grant: only in IDLE, suppressed while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !RST) begin
            if (REQ0 && REQ1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = REQ0;
                gnt1 = REQ1;
            end
        end
    end

    // Winner operand mux.
    always_comb begin
        op_data  = gnt1 ? D_IN1  : D_IN0;
        op_shamt = gnt1 ? SHAMT1 : SHAMT0;
        op_arith = gnt1 ? ARITH1 : ARITH0;
    end

    // Next-state, step shifter and result capture.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ar_d    = ar_q;
        last_d  = last_q;
        rid_d   = rid_q;
        fill    = ar_q & data_q[D_WIDTH-1];
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    data_d = op_data;
                    rem_d  = op_shamt;
                    ar_d   = op_arith;
                    last_d = gnt1;
                    rid_d  = gnt1;
                    if (op_shamt == '0) begin
                        state_d = DONE;
                        dout_d  = op_data;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (rem_q >= SH_W'(2)) begin
                    data_d = {{2{fill}}, data_q[D_WIDTH-1:2]};
                    rem_d  = rem_q - SH_W'(2);
                end else begin
                    data_d = {fill, data_q[D_WIDTH-1:1]};
                    rem_d  = rem_q - SH_W'(1);
                end
                if (rem_d == '0) begin
                    state_d = DONE;
                    dout_d  = data_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            ar_q    <= 1'b0;
            last_q  <= 1'b1;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ar_q    <= ar_d;
            last_q  <= last_d;
            rid_q   <= rid_d;
        end
    end

    assign GNT0  = gnt0;
    assign GNT1  = gnt1;
    assign BUSY  = (state_q != IDLE);
    assign VALID = (state_q == DONE);
    assign RID   = rid_q;
    assign D_OUT = dout_q;

endmodule

// File: tb/tb_bsr_seq.sv
// tb_bsr_seq: scoreboard bench for bsr_seq.
// Expected results are queued at grant and checked at VALID.
module tb_bsr_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0, REQ1;
    logic [4:0]  SHAMT0, SHAMT1;
    logic        ARITH0, ARITH1;
    logic [31:0] D_IN0, D_IN1;
    logic        GNT0, GNT1, BUSY, VALID, RID;
    logic [31:0] D_OUT;

    bsr_seq #(.D_WIDTH(32), .SH_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1),
        .SHAMT0(SHAMT0), .SHAMT1(SHAMT1),
        .ARITH0(ARITH0), .ARITH1(ARITH1),
        .D_IN0(D_IN0), .D_IN1(D_IN1),
        .GNT0(GNT0), .GNT1(GNT1),
        .BUSY(BUSY), .VALID(VALID),
        .RID(RID), .D_OUT(D_OUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic        rid;
        logic [31:0] data;
        int          t_gnt;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic tb_last;

    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [4:0] sh,
                                          input logic ar);
        if (ar) return $unsigned($signed(d) >>> sh);
        return d >> sh;
    endfunction

    function automatic int lat_of(input logic [4:0] sh);
        return (int'(sh) + 1) / 2 + 1;
    endfunction

    task automatic set_port(input logic p, input logic [31:0] d,
                            input logic [4:0] sh, input logic ar,
                            input logic req);
        if (!p) begin
            D_IN0 = d; SHAMT0 = sh; ARITH0 = ar; REQ0 = req;
        end else begin
            D_IN1 = d; SHAMT1 = sh; ARITH1 = ar; REQ1 = req;
        end
    endtask

    // One request from one port, result checked against the scoreboard.
    task automatic run_op(input logic p, input logic [31:0] d,
                          input logic [4:0] sh, input logic ar,
                          input logic [31:0] exp_d, input string name);
        bit   got;
        exp_t e;
        @(negedge CLK);
        set_port(p, d, sh, ar, 1'b1);
        #1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if ((p ? GNT1 : GNT0) === 1'b1) begin got = 1; break; end
            @(negedge CLK); #1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s grant: got none in 40 cycles, want GNT%0d", name, p);
            set_port(p, d, sh, ar, 1'b0);
            return;
        end
        sb.push_back('{rid: p, data: exp_d, t_gnt: cyc, lat: lat_of(sh)});
        tb_last = p;
        @(negedge CLK);
        // Scramble operands: they must be ignored after the grant cycle.
        set_port(p, ~d, sh + 5'd3, ~ar, 1'b0);
        #1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (VALID === 1'b1) begin got = 1; break; end
            @(negedge CLK); #1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s valid: got none in 40 cycles, want VALID", name);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        tests++;
        if (D_OUT !== e.data) begin
            fails++;
            $display("FAIL %s data: got %h want %h", name, D_OUT, e.data);
        end
        tests++;
        if (RID !== e.rid) begin
            fails++;
            $display("FAIL %s rid: got %0d want %0d", name, RID, e.rid);
        end
        tests++;
        if (cyc - e.t_gnt != e.lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d",
                     name, cyc - e.t_gnt, e.lat);
        end
        tests++;
        if (BUSY !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_at_valid: got %b want 1", name, BUSY);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        set_port(1'b0, 32'h0000_0011, 5'd0, 1'b0, 1'b1);
        set_port(1'b1, 32'h0000_0022, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            tests++;
            if ({GNT0, GNT1, BUSY, VALID, RID, D_OUT} !== 37'd0) begin
                fails++;
                $display("FAIL reset_outputs: got gnt=%b%b busy=%b valid=%b rid=%b dout=%h want all 0",
                         GNT0, GNT1, BUSY, VALID, RID, D_OUT);
            end
        end
        RST = 1'b0;
        #1;
        tests++;
        if ({GNT0, GNT1} !== 2'b10) begin
            fails++;
            $display("FAIL reset_first_grant: got gnt0/1=%b%b want 10", GNT0, GNT1);
        end
        tb_last = 1'b0;
        @(negedge CLK);
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_arith;
        run_op(1'b0, 32'h8000_0000, 5'd5, 1'b1, 32'hFC00_0000, "arith5");
        run_op(1'b0, 32'h8000_0000, 5'd5, 1'b0, 32'h0400_0000, "logic5");
    endtask

    task automatic test_zero_max;
        run_op(1'b0, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, "zero");
        run_op(1'b1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "max_arith");
        run_op(1'b0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "max_logic");
    endtask

    task automatic test_contention;
        exp_t e;
        logic prev, ep;
        int   ngnt, last_t;
        @(negedge CLK);
        set_port(1'b0, 32'hA5A5_A5A5, 5'd4, 1'b1, 1'b1);
        set_port(1'b1, 32'hF000_000F, 5'd4, 1'b0, 1'b1);
        #1;
        prev = tb_last;
        ngnt = 0;
        last_t = -1;
        for (int i = 0; i < 60; i++) begin
            if (ngnt >= 6 && sb.size() == 0) break;
            if (VALID === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL cont_valid: got unexpected VALID, want none");
                end else begin
                    e = sb.pop_front();
                    if (D_OUT !== e.data || RID !== e.rid ||
                        cyc - e.t_gnt != e.lat) begin
                        fails++;
                        $display("FAIL cont_result: got dout=%h rid=%0d lat=%0d want %h %0d %0d",
                                 D_OUT, RID, cyc - e.t_gnt, e.data, e.rid, e.lat);
                    end
                end
            end
            if (GNT0 === 1'b1 || GNT1 === 1'b1) begin
                ep = ~prev;
                tests++;
                if ({GNT0, GNT1} !== (ep ? 2'b01 : 2'b10)) begin
                    fails++;
                    $display("FAIL cont_order: got gnt0/1=%b%b want port %0d",
                             GNT0, GNT1, ep);
                end
                if (last_t >= 0) begin
                    tests++;
                    if (cyc - last_t != 4) begin
                        fails++;
                        $display("FAIL cont_gap: got %0d want 4", cyc - last_t);
                    end
                end
                sb.push_back('{rid: ep,
                               data: ep ? 32'h0F00_0000 : 32'hFA5A_5A5A,
                               t_gnt: cyc, lat: 3});
                prev = ep;
                last_t = cyc;
                ngnt++;
            end
            @(negedge CLK);
            if (ngnt >= 6) begin REQ0 = 1'b0; REQ1 = 1'b0; end
            #1;
        end
        tests++;
        if (ngnt != 6 || sb.size() != 0) begin
            fails++;
            $display("FAIL cont_count: got %0d grants %0d pending want 6 0",
                     ngnt, sb.size());
            sb.delete();
        end
        tb_last = prev;
    endtask

    task automatic test_busy_block;
        exp_t e;
        bit   got, seen_v, blocked;
        @(negedge CLK);
        set_port(1'b0, 32'h0000_8000, 5'd10, 1'b0, 1'b1);
        #1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (GNT0 === 1'b1) begin got = 1; break; end
            @(negedge CLK); #1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL busy_gnt0: got none want GNT0");
        end
        sb.push_back('{rid: 1'b0, data: 32'h0000_0020, t_gnt: cyc, lat: 6});
        @(negedge CLK);
        REQ0 = 1'b0;
        set_port(1'b1, 32'h8000_0003, 5'd1, 1'b1, 1'b1);
        #1;
        seen_v = 0;
        blocked = 1;
        for (int i = 0; i < 20; i++) begin
            if (VALID === 1'b1) begin
                seen_v = 1;
                e = sb.pop_front();
                tests++;
                if (D_OUT !== e.data || RID !== e.rid ||
                    cyc - e.t_gnt != e.lat) begin
                    fails++;
                    $display("FAIL busy_result0: got dout=%h rid=%0d lat=%0d want %h %0d %0d",
                             D_OUT, RID, cyc - e.t_gnt, e.data, e.rid, e.lat);
                end
                if (GNT1 === 1'b1) blocked = 0;
                @(negedge CLK); #1;
                break;
            end
            if (GNT1 === 1'b1) blocked = 0;
            @(negedge CLK); #1;
        end
        tests++;
        if (!blocked || !seen_v) begin
            fails++;
            $display("FAIL busy_block: got blocked=%0d valid_seen=%0d want 1 1",
                     blocked, seen_v);
            sb.delete();
        end
        tests++;
        if (GNT1 !== 1'b1) begin
            fails++;
            $display("FAIL busy_gnt1_after: got %b want 1", GNT1);
        end
        sb.push_back('{rid: 1'b1, data: 32'hC000_0001, t_gnt: cyc, lat: 2});
        tb_last = 1'b1;
        @(negedge CLK);
        REQ1 = 1'b0;
        #1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (VALID === 1'b1) begin got = 1; break; end
            @(negedge CLK); #1;
        end
        tests++;
        if (!got || sb.size() == 0) begin
            fails++;
            $display("FAIL busy_result1: got no VALID want port 1 result");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (D_OUT !== e.data || RID !== e.rid ||
                cyc - e.t_gnt != e.lat) begin
                fails++;
                $display("FAIL busy_result1: got dout=%h rid=%0d lat=%0d want %h %0d %0d",
                         D_OUT, RID, cyc - e.t_gnt, e.data, e.rid, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit got, any_v;
        @(negedge CLK);
        set_port(1'b0, 32'hDEAD_BEEF, 5'd20, 1'b1, 1'b1);
        #1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (GNT0 === 1'b1) begin got = 1; break; end
            @(negedge CLK); #1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rmid_gnt: got none want GNT0");
        end
        @(negedge CLK);
        REQ0 = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        tests++;
        if ({BUSY, VALID, RID, D_OUT} !== 35'd0) begin
            fails++;
            $display("FAIL rmid_state: got busy=%b valid=%b rid=%b dout=%h want all 0",
                     BUSY, VALID, RID, D_OUT);
        end
        tb_last = 1'b1;
        any_v = 0;
        for (int i = 0; i < 15; i++) begin
            if (VALID === 1'b1) any_v = 1;
            @(negedge CLK); #1;
        end
        tests++;
        if (any_v) begin
            fails++;
            $display("FAIL rmid_no_valid: got VALID want none");
        end
    endtask

    task automatic test_random;
        logic        p, ar;
        logic [31:0] d;
        logic [4:0]  sh;
        for (int i = 0; i < 6; i++) begin
            p  = 1'($urandom_range(0, 1));
            ar = 1'($urandom_range(0, 1));
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            run_op(p, d, sh, ar, model(d, sh, ar), "random");
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0;
        SHAMT0 = '0; SHAMT1 = '0;
        ARITH0 = 1'b0; ARITH1 = 1'b0;
        D_IN0 = '0; D_IN1 = '0;
        tb_last = 1'b1;
        test_reset();
        test_arith();
        test_zero_max();
        test_contention();
        test_busy_block();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
